// File: rtl/rv32i_multicycle_core_p.sv
// Purpose : multicycle RV32I core (ALU, LW/SW, branches, JAL/JALR, LUI/AUIPC) on one shared word-wide memory port.
// Latency : R/I/LUI/AUIPC 4 cycles, LW 5, SW 4, branch 3, JAL/JALR 3; 31-cycle register-clear sweep after reset if enabled.
// Backpressure: ena=0 freezes every register and suppresses memory and register-file writes; outputs track held state.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             global advance enable
//   mem_addr        word-aligned byte address (PC in FETCH, ALUOut in MEM_RD/MEM_WR)
//   mem_rd_data     combinational read data for mem_addr
//   mem_wr_data     store data (B operand)
//   mem_wr_ena      memory write strobe, one cycle per SW
//   PC              address of the next instruction to fetch
//   halted          set once an illegal instruction has been decoded
//   instr_retired   pulse on the final cycle of every completed instruction

package rv32i_multicycle_core_p_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;
endpackage

// Purpose : 32x32 register file, x0 hardwired to zero.
// Latency : reads combinational, write lands on the clock edge.
// Backpressure: none; the caller gates wr_ena.
module register_file (
    input  logic        clk,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic [31:0] rd_data1,
    output logic [31:0] rd_data2
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (wr_ena && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'd0 : regs[rd_addr1];
    assign rd_data2 = (rd_addr2 == 5'd0) ? 32'd0 : regs[rd_addr2];
endmodule

// Purpose : RV32I integer ALU.
// Latency : combinational.
// Backpressure: none.
module alu_behavioural
    import rv32i_multicycle_core_p_pkg::*;
(
    input  alu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res
);
    always_comb begin
        res = 32'd0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_SLL:  res = a << b[4:0];
            ALU_SLT:  res = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'd0, a < b};
            ALU_XOR:  res = a ^ b;
            ALU_SRL:  res = a >> b[4:0];
            ALU_SRA:  res = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            default:  res = 32'd0;
        endcase
    end
endmodule

module rv32i_multicycle_core_p
    import rv32i_multicycle_core_p_pkg::*;
#(
    parameter logic [31:0] PC_START_ADDRESS = 32'h0,
    parameter bit          REG_RESET_ZERO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_ena,
    output logic [31:0] PC,
    output logic        halted,
    output logic        instr_retired
);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_WB, S_ADDR,
        S_MEM_RD, S_LD_WB, S_MEM_WR, S_BR, S_JUMP, S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q, pc_old_q, ir_q, a_q, b_q, alu_out_q, mdr_q;
    logic [4:0]  init_cnt_q;

    // Instruction fields and immediates, all taken from the latched IR.
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'd0};

    // Register file
    logic        rf_wr_req, rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data, rf_rd1, rf_rd2;

    always_comb begin
        rf_wr_req  = 1'b0;
        rf_wr_addr = rd;
        rf_wr_data = 32'd0;
        case (state_q)
            S_INIT:  begin rf_wr_req = 1'b1; rf_wr_addr = init_cnt_q; end
            S_WB:    begin rf_wr_req = 1'b1; rf_wr_data = alu_out_q; end
            S_LD_WB: begin rf_wr_req = 1'b1; rf_wr_data = mdr_q; end
            S_JUMP:  begin rf_wr_req = 1'b1; rf_wr_data = pc_old_q + 32'd4; end
            default: rf_wr_req = 1'b0;
        endcase
    end

    // A reset edge must not commit a write from the instruction it aborts.
    assign rf_wr_ena = rf_wr_req && ena && !rst;

    register_file u_rf (
        .clk      (clk),
        .wr_ena   (rf_wr_ena),
        .wr_addr  (rf_wr_addr),
        .wr_data  (rf_wr_data),
        .rd_addr1 (rs1),
        .rd_addr2 (rs2),
        .rd_data1 (rf_rd1),
        .rd_data2 (rf_rd2)
    );

    // EXEC operand/operation select and legality
    alu_op_t     alu_op, rtype_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        exec_legal;

    always_comb begin
        case (funct3)
            3'b000:  rtype_op = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  rtype_op = ALU_SLL;
            3'b010:  rtype_op = ALU_SLT;
            3'b011:  rtype_op = ALU_SLTU;
            3'b100:  rtype_op = ALU_XOR;
            3'b101:  rtype_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  rtype_op = ALU_OR;
            default: rtype_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_op     = ALU_ADD;
        alu_a      = a_q;
        alu_b      = b_q;
        exec_legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_op     = rtype_op;
                exec_legal = (funct7 == 7'h00) ||
                             ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OP_ITYPE: begin
                // ADDI has no subtract form, so imm[10] must not leak into funct7[5].
                alu_op = (funct3 == 3'b000) ? ALU_ADD : rtype_op;
                alu_b  = imm_i;
                case (funct3)
                    3'b001:  exec_legal = (funct7 == 7'h00);
                    3'b101:  exec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    default: exec_legal = 1'b1;
                endcase
            end
            OP_LUI:   begin alu_a = 32'd0;    alu_b = imm_u; exec_legal = 1'b1; end
            OP_AUIPC: begin alu_a = pc_old_q; alu_b = imm_u; exec_legal = 1'b1; end
            default:  exec_legal = 1'b0;
        endcase
    end

    alu_behavioural u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .res (alu_res)
    );

    // Branch condition on latched operands
    logic br_taken;
    always_comb begin
        case (funct3)
            3'b000:  br_taken = (a_q == b_q);
            3'b001:  br_taken = (a_q != b_q);
            3'b100:  br_taken = ($signed(a_q) <  $signed(b_q));
            3'b101:  br_taken = ($signed(a_q) >= $signed(b_q));
            3'b110:  br_taken = (a_q <  b_q);
            default: br_taken = (a_q >= b_q);
        endcase
    end

    // JALR uses A latched in DECODE, so rd == rs1 cannot corrupt the target.
    logic [31:0] jump_tgt;
    assign jump_tgt = (opcode == OP_JALR) ? ((a_q + imm_i) & ~32'd1) : (pc_old_q + imm_j);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REG_RESET_ZERO ? S_INIT : S_FETCH;
            pc_q       <= PC_START_ADDRESS;
            pc_old_q   <= 32'd0;
            ir_q       <= 32'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            alu_out_q  <= 32'd0;
            mdr_q      <= 32'd0;
            init_cnt_q <= 5'd1;
        end else if (ena) begin
            case (state_q)
                S_INIT: begin
                    if (init_cnt_q == 5'd31) state_q <= S_FETCH;
                    else                     init_cnt_q <= init_cnt_q + 5'd1;
                end
                S_FETCH: begin
                    ir_q     <= mem_rd_data;
                    pc_old_q <= pc_q;
                    pc_q     <= pc_q + 32'd4;
                    state_q  <= S_DECODE;
                end
                S_DECODE: begin
                    a_q       <= rf_rd1;
                    b_q       <= rf_rd2;
                    alu_out_q <= pc_old_q + imm_b;
                    case (opcode)
                        OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC: state_q <= S_EXEC;
                        OP_LOAD, OP_STORE:                    state_q <= S_ADDR;
                        OP_BRANCH:                            state_q <= S_BR;
                        OP_JAL, OP_JALR:                      state_q <= S_JUMP;
                        default:                              state_q <= S_HALT;
                    endcase
                end
                S_EXEC: begin
                    if (exec_legal) begin
                        alu_out_q <= alu_res;
                        state_q   <= S_WB;
                    end else begin
                        state_q <= S_HALT;
                    end
                end
                S_ADDR: begin
                    alu_out_q <= a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
                    if (funct3 != 3'b010)        state_q <= S_HALT;
                    else if (opcode == OP_LOAD)  state_q <= S_MEM_RD;
                    else                         state_q <= S_MEM_WR;
                end
                S_MEM_RD: begin
                    mdr_q   <= mem_rd_data;
                    state_q <= S_LD_WB;
                end
                S_BR: begin
                    if ((funct3 == 3'b010) || (funct3 == 3'b011)) begin
                        state_q <= S_HALT;
                    end else begin
                        if (br_taken) pc_q <= alu_out_q;
                        state_q <= S_FETCH;
                    end
                end
                S_JUMP: begin
                    pc_q    <= jump_tgt;
                    state_q <= S_FETCH;
                end
                S_WB, S_LD_WB, S_MEM_WR: state_q <= S_FETCH;
                S_HALT:                  state_q <= S_HALT;
                default:                 state_q <= S_HALT;
            endcase
        end
    end

    // Outputs
    logic [31:0] addr_sel;
    assign addr_sel    = ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) ? alu_out_q : pc_q;
    assign mem_addr    = {addr_sel[31:2], 2'b00};
    assign mem_wr_data = b_q;
    assign mem_wr_ena  = (state_q == S_MEM_WR) && ena && !rst;
    assign PC          = pc_q;
    assign halted      = (state_q == S_HALT);
    assign instr_retired = ena && !rst &&
                           ((state_q == S_WB) || (state_q == S_LD_WB) || (state_q == S_MEM_WR) ||
                            (state_q == S_BR) || (state_q == S_JUMP));
endmodule

// File: tb/tb_rv32i_multicycle_core_p.sv
// Bench for rv32i_multicycle_core_p: a program in a behavioural memory stores its results;
// every store it will perform is queued as an expected (address, data) pair and a monitor
// pops and compares each real write. Timing is checked from recorded retire-pulse edges.
module tb_rv32i_multicycle_core_p;
    localparam logic [31:0] START = 32'h100;

    localparam logic [6:0] OPI    = 7'b0010011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] OPLD   = 7'b0000011;
    localparam logic [6:0] OPST   = 7'b0100011;
    localparam logic [6:0] OPBR   = 7'b1100011;
    localparam logic [6:0] OPJAL  = 7'b1101111;
    localparam logic [6:0] OPJALR = 7'b1100111;
    localparam logic [6:0] OPLUI  = 7'b0110111;
    localparam logic [6:0] OPAUI  = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [31:0] mem_addr, mem_rd_data, mem_wr_data, pc;
    logic        mem_wr_ena, halted, instr_retired;

    rv32i_multicycle_core_p #(
        .PC_START_ADDRESS (START),
        .REG_RESET_ZERO   (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ena    (mem_wr_ena),
        .PC            (pc),
        .halted        (halted),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign mem_rd_data = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_wr_ena) mem[mem_addr[11:2]] = mem_wr_data;

    int edges = 0;
    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int ret_cnt = 0;
    int ret_edge [0:255];
    logic [31:0] exp_addr_q [$];
    logic [31:0] exp_data_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Write and retire monitor
    initial begin
        for (int i = 0; i < 256; i++) ret_edge[i] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && instr_retired) begin
                ret_cnt++;
                if (ret_cnt < 256) ret_edge[ret_cnt] = edges;
            end
            if (!rst && mem_wr_ena) begin
                if (exp_addr_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wr_data);
                end else begin
                    check("wr_addr", mem_addr, exp_addr_q.pop_front());
                    check("wr_data", mem_wr_data, exp_data_q.pop_front());
                end
            end
        end
    end

    // Encoders
    function automatic logic [31:0] i_t(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction
    function automatic logic [31:0] s_t(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPST};
    endfunction
    function automatic logic [31:0] b_t(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPBR};
    endfunction
    function automatic logic [31:0] j_t(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPJAL};
    endfunction
    function automatic logic [31:0] u_t(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    logic [31:0] pa;
    int          n_emit;
    task automatic emit(input logic [31:0] w);
        mem[pa[11:2]] = w;
        pa     = pa + 32'd4;
        n_emit = n_emit + 1;
    endtask
    task automatic sw_exp(input logic [4:0] rs2, input logic [4:0] rs1, input logic [31:0] imm,
                          input logic [31:0] addr, input logic [31:0] data);
        emit(s_t(rs2, rs1, imm));
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(data);
    endtask

    int          idx_x6, idx_lw, idx_l0;
    logic [31:0] auipc_pc, jmp_base, ill_pc, pc_hold;
    int          ret_hold;
    bit          found;

    initial begin
        rst = 1'b1;
        ena = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        pa = START;
        n_emit = 0;

        // Arithmetic basics
        emit(i_t(OPI, 3'b000, 1, 0, 32'd5));
        emit(i_t(OPI, 3'b000, 2, 0, -32'sd3));
        emit(r_t(7'h00, 3'b000, 3, 1, 2));
        emit(r_t(7'h20, 3'b000, 4, 2, 1));
        sw_exp(3, 0, 32'h600, 32'h600, 32'd2);
        sw_exp(4, 0, 32'h604, 32'h604, 32'hFFFF_FFF8);
        sw_exp(31, 0, 32'h608, 32'h608, 32'd0);
        sw_exp(17, 0, 32'h60C, 32'h60C, 32'd0);
        // Remaining ALU ops with x1=5, x2=-3
        emit(r_t(7'h00, 3'b010, 12, 2, 1));
        emit(r_t(7'h00, 3'b011, 13, 2, 1));
        emit(r_t(7'h20, 3'b101, 14, 2, 1));
        emit(r_t(7'h00, 3'b101, 15, 2, 1));
        emit(i_t(OPI, 3'b101, 16, 2, 32'h401));
        emit(i_t(OPI, 3'b100, 17, 1, -32'sd1));
        emit(r_t(7'h00, 3'b001, 19, 1, 1));
        emit(r_t(7'h00, 3'b110, 20, 1, 2));
        emit(r_t(7'h00, 3'b111, 21, 1, 2));
        auipc_pc = pa;
        emit(u_t(OPAUI, 18, 20'h00001));
        sw_exp(12, 0, 32'h620, 32'h620, 32'd1);
        sw_exp(13, 0, 32'h624, 32'h624, 32'd0);
        sw_exp(14, 0, 32'h628, 32'h628, 32'hFFFF_FFFF);
        sw_exp(15, 0, 32'h62C, 32'h62C, 32'h07FF_FFFF);
        sw_exp(16, 0, 32'h630, 32'h630, 32'hFFFF_FFFE);
        sw_exp(17, 0, 32'h634, 32'h634, 32'hFFFF_FFFA);
        sw_exp(19, 0, 32'h638, 32'h638, 32'h0000_00A0);
        sw_exp(20, 0, 32'h63C, 32'h63C, 32'hFFFF_FFFD);
        sw_exp(21, 0, 32'h640, 32'h640, 32'd5);
        sw_exp(18, 0, 32'h644, 32'h644, auipc_pc + 32'h1000);
        // Store / load
        emit(u_t(OPLUI, 5, 20'hDEADC));
        emit(i_t(OPI, 3'b000, 5, 5, -32'sd273));
        emit(i_t(OPI, 3'b000, 6, 0, 32'h40));
        idx_x6 = n_emit;
        sw_exp(5, 6, 32'd4, 32'h44, 32'hDEAD_BEEF);
        emit(i_t(OPLD, 3'b010, 7, 6, 32'd4));
        idx_lw = n_emit;
        sw_exp(7, 0, 32'h648, 32'h648, 32'hDEAD_BEEF);
        // Countdown loop
        emit(i_t(OPI, 3'b000, 1, 0, 32'd3));
        idx_l0 = n_emit;
        emit(i_t(OPI, 3'b000, 1, 1, -32'sd1));
        emit(b_t(3'b001, 1, 0, -32'sd4));
        sw_exp(1, 0, 32'h64C, 32'h64C, 32'd0);
        // Signed taken / unsigned not-taken branches
        emit(b_t(3'b100, 2, 1, 32'd8));
        emit(s_t(0, 0, 32'h6F0));
        emit(b_t(3'b110, 2, 1, 32'd8));
        sw_exp(3, 0, 32'h650, 32'h650, 32'd2);
        // Jumps, including jalr with rd == rs1
        jmp_base = pa;
        emit(j_t(1, 32'd12));
        emit(i_t(OPI, 3'b000, 0, 0, 32'd7));
        emit(j_t(11, 32'd8));
        emit(i_t(OPJALR, 3'b000, 1, 1, 32'd0));
        sw_exp(1, 0, 32'h654, 32'h654, jmp_base + 32'd16);
        sw_exp(11, 0, 32'h658, 32'h658, jmp_base + 32'd12);
        sw_exp(0, 0, 32'h65C, 32'h65C, 32'd0);
        // Store stalled by ena, then illegal opcode followed by a store that must never happen
        sw_exp(3, 0, 32'h700, 32'h700, 32'd2);
        ill_pc = pa;
        emit(32'h0000_007F);
        emit(s_t(3, 0, 32'h704));

        repeat (3) tick();
        check("rst_pc", pc, START);
        check("rst_mem_addr", mem_addr, START);
        check("rst_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", {31'd0, instr_retired}, 32'd0);
        rst = 1'b0;

        while (edges < 30) tick();
        check("init_pc_hold", pc, START);
        check("init_no_retire", ret_cnt, 0);
        while (edges < 32) tick();
        check("first_fetch_pc", pc, START + 32'd4);

        for (int k = 0; k < 200 && ret_cnt < 4; k++) tick();
        check("arith_4th_retire_edge", ret_edge[4], 46);

        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            tick();
            if (mem_wr_ena && (mem_addr == 32'h700)) found = 1'b1;
        end
        check("stall_store_reached", {31'd0, found}, 32'd1);
        if (found) begin
            ena = 1'b0;
            pc_hold = pc;
            ret_hold = ret_cnt;
            for (int k = 0; k < 5; k++) begin
                tick();
                check("stall_no_write", {31'd0, mem_wr_ena}, 32'd0);
            end
            check("stall_pc_hold", pc, pc_hold);
            check("stall_no_retire", ret_cnt, ret_hold);
            ena = 1'b1;
        end

        check("sw_lw_cycles", ret_edge[idx_lw] - ret_edge[idx_x6], 9);
        check("loop_cycles", ret_edge[idx_l0 + 7] - ret_edge[idx_l0], 25);

        for (int k = 0; k < 200 && !halted; k++) tick();
        check("halted", {31'd0, halted}, 32'd1);
        check("halt_pc", pc, ill_pc + 32'd4);
        ret_hold = ret_cnt;
        repeat (10) tick();
        check("halt_pc_frozen", pc, ill_pc + 32'd4);
        check("halt_no_retire", ret_cnt, ret_hold);
        check("all_writes_seen", exp_addr_q.size(), 0);

        rst = 1'b1;
        repeat (2) tick();
        check("rerst_halted", {31'd0, halted}, 32'd0);
        check("rerst_pc", pc, START);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
